hazard_control: RTL
===================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; 0 clears all state immediately, independent of clock.
REQ-003 SHALL have inputs rs_id, rd_id (3 each) and uses_rs_id, uses_rd_id (1 each): source registers of the instruction in ID and their use flags.
REQ-004 SHALL have inputs rs_ex, rd_ex (3 each), the source registers of the instruction in EX, taken from the ID/EX register outputs.
REQ-005 SHALL have inputs op_mem_read_ex, op_reg_write_ex (1 each) and wa_ex (3): EX-stage load flag, write-enable and write address.
REQ-006 SHALL have inputs op_reg_write_mem, op_mem_read_mem (1 each), wa_mem (3), op_reg_write_wb (1) and wa_wb (3).
REQ-007 SHALL have inputs branch_taken_ex (1), halt_ex (1) and resume (1).
REQ-008 SHALL have outputs op_pc_write, op_if_id_write, op_if_id_flush and op_id_ex_write (1 each); op_id_ex_write=0 makes ID/EX load a bubble.
REQ-009 SHALL have outputs fwd_a_sel, fwd_b_sel (2 each), with 00=register file, 01=MEM result, 10=WB result; and halted (1).
REQ-010 SHALL have outputs stall_count, flush_count (16 each): saturating event counters.

Function
REQ-011 SHALL implement FSM states RUN, STALL2 and HALT.
REQ-012 SHALL define load_use = op_mem_read_ex & op_reg_write_ex & ((uses_rs_id & wa_ex==rs_id) | (uses_rd_id & wa_ex==rd_id)).
REQ-013 In RUN with no event, SHALL drive op_pc_write=op_if_id_write=op_id_ex_write=1 and op_if_id_flush=0.
REQ-014 In RUN with branch_taken_ex=1, SHALL drive op_pc_write=1, op_if_id_flush=1, op_id_ex_write=0 and op_if_id_write=1; next state SHALL be RUN.
REQ-015 In RUN with load_use=1 and branch_taken_ex=0, SHALL drive op_pc_write=op_if_id_write=op_id_ex_write=0 and op_if_id_flush=0; next state SHALL be STALL2.
REQ-016 In STALL2, SHALL hold PC and IF/ID, insert a bubble (op_id_ex_write=0), then return to RUN; total load-use penalty SHALL be exactly 2 cycles.
REQ-017 branch_taken_ex SHALL have priority over load_use in every state except HALT; in STALL2 it SHALL produce REQ-014 outputs and go to RUN.
REQ-018 halt_ex=1 in RUN or STALL2 SHALL take priority over branch and load_use: all four controls 0, next state HALT.
REQ-019 In HALT, SHALL drive all write enables 0, op_if_id_flush=0 and halted=1; resume=1 SHALL return to RUN on the next edge.
REQ-020 fwd_a_sel for rs_ex SHALL be 01 if op_reg_write_mem & !op_mem_read_mem & wa_mem==rs_ex; else 10 if op_reg_write_wb & wa_wb==rs_ex; else 00.
REQ-021 fwd_b_sel SHALL follow REQ-020 using rd_ex; MEM SHALL win over WB when both match.
REQ-022 Forwarding outputs SHALL be combinational and independent of FSM state.
REQ-023 stall_count SHALL increment once per cycle with op_id_ex_write=0 caused by load_use or STALL2, and SHALL saturate at 16'hFFFF.
REQ-024 flush_count SHALL increment once per cycle with op_if_id_flush=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-025 While reset=0, state SHALL be RUN and both counters 0.
REQ-026 While reset=0, op_pc_write, op_if_id_write and op_id_ex_write SHALL be 0, op_if_id_flush=0, fwd sels=00 and halted=0.
REQ-027 Reset asserted in STALL2 or HALT SHALL abort that state; the first edge after release SHALL operate from RUN.

Verification
REQ-028 Load in EX, wa_ex=3 with rs_id=3 and uses_rs_id=1: 2 cycles of pc/if_id/id_ex_write=0, then all 1; stall_count=2.
REQ-029 Load-use and branch_taken_ex in the same cycle: op_if_id_flush=1, op_pc_write=1, op_id_ex_write=0; state stays RUN; flush_count=1, stall_count=0.
REQ-030 wa_mem=wa_wb=rs_ex=5, both write-enables 1, op_mem_read_mem=0: fwd_a_sel=01; with op_mem_read_mem=1: fwd_a_sel=10.
REQ-031 halt_ex pulse, then resume after 4 cycles: halted=1 and write enables 0 for 4 cycles, then RUN.
REQ-032 Force stall_count to 16'hFFFE, then 3 load-use stalls: stall_count holds at 16'hFFFF.
REQ-033 reset driven low mid-cycle while in STALL2: outputs reach reset values without a clock edge, and counters read 0.

Source files
------------

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall FSM (RUN/STALL2/HALT), branch flush, EX operand forwarding, event counters.
// Control and forwarding outputs are combinational from state and inputs; counters and halted update on the rising clock edge.
module hazard_control (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  rs_id,
   input  logic [2:0]  rd_id,
   input  logic        uses_rs_id,
   input  logic        uses_rd_id,
   input  logic [2:0]  rs_ex,
   input  logic [2:0]  rd_ex,
   input  logic        op_mem_read_ex,
   input  logic        op_reg_write_ex,
   input  logic [2:0]  wa_ex,
   input  logic        op_reg_write_mem,
   input  logic        op_mem_read_mem,
   input  logic [2:0]  wa_mem,
   input  logic        op_reg_write_wb,
   input  logic [2:0]  wa_wb,
   input  logic        branch_taken_ex,
   input  logic        halt_ex,
   input  logic        resume,
   output logic        op_pc_write,
   output logic        op_if_id_write,
   output logic        op_if_id_flush,
   output logic        op_id_ex_write,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        halted,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {RUN, STALL2, HALT} state_t;

   state_t state;
   state_t next_state;
   logic   load_use;
   logic   pc_w, if_id_w, if_id_fl, id_ex_w;
   logic   stall_evt, flush_evt;

   assign load_use = op_mem_read_ex & op_reg_write_ex &
                     ((uses_rs_id & (wa_ex == rs_id)) | (uses_rd_id & (wa_ex == rd_id)));

   always_comb begin
      next_state = state;
      pc_w       = 1'b0;
      if_id_w    = 1'b0;
      if_id_fl   = 1'b0;
      id_ex_w    = 1'b0;
      stall_evt  = 1'b0;
      flush_evt  = 1'b0;
      case (state)
         RUN, STALL2: begin
            if (halt_ex) begin
               next_state = HALT;
            end else if (branch_taken_ex) begin
               // wrong-path fetch is squashed; the bubble also covers any pending load-use
               pc_w       = 1'b1;
               if_id_w    = 1'b1;
               if_id_fl   = 1'b1;
               flush_evt  = 1'b1;
               next_state = RUN;
            end else if (state == STALL2) begin
               stall_evt  = 1'b1;
               next_state = RUN;
            end else if (load_use) begin
               stall_evt  = 1'b1;
               next_state = STALL2;
            end else begin
               pc_w    = 1'b1;
               if_id_w = 1'b1;
               id_ex_w = 1'b1;
            end
         end
         HALT: begin
            if (resume) next_state = RUN;
         end
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         halted      <= 1'b0;
         stall_count <= 16'h0000;
         flush_count <= 16'h0000;
      end else begin
         state  <= next_state;
         halted <= (next_state == HALT);
         if (stall_evt && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
         if (flush_evt && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      end
   end

   // Reset gates the combinational controls so they go quiet without waiting for an edge
   assign op_pc_write    = reset & pc_w;
   assign op_if_id_write = reset & if_id_w;
   assign op_if_id_flush = reset & if_id_fl;
   assign op_id_ex_write = reset & id_ex_w;

   function automatic logic [1:0] fwd_sel(input logic [2:0] src);
      if (op_reg_write_mem && !op_mem_read_mem && wa_mem == src) return 2'b01;
      if (op_reg_write_wb && wa_wb == src)                       return 2'b10;
      return 2'b00;
   endfunction

   assign fwd_a_sel = reset ? fwd_sel(rs_ex) : 2'b00;
   assign fwd_b_sel = reset ? fwd_sel(rd_ex) : 2'b00;

endmodule
